perspective_viewport: RTL and testbench
=======================================

Name: perspective_viewport

Overview:
- Downstream stage of the binary16 model-view-projection transform.
- Consumes clip-space vertices (x, y, z, w in binary16) and performs the perspective divide, then the viewport mapping.
- Emits integer pixel coordinates plus a 16-bit unsigned depth for the rasterizer.
- The upstream stage has no backpressure, so the block buffers vertices in a small input FIFO and runs an iterative mantissa divider.

Parameters:
- H_RES, 1280, horizontal resolution in pixels
- V_RES, 720, vertical resolution in pixels
- FIFO_DEPTH, 4, input FIFO entries (power of two, >=2)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- x  input  16  binary16 clip-space x
- y  input  16  binary16 clip-space y
- z  input  16  binary16 clip-space z
- w  input  16  binary16 clip-space w
- data_valid_in  input  1  vertex present this cycle; no ready is returned
- px_out  output  11  screen x, 0..H_RES-1
- py_out  output  10  screen y, 0..V_RES-1, row 0 at top
- depth_out  output  16  unsigned depth, 0 = near, 0xFFFF = far
- clip_out  output  1  vertex rejected; px/py/depth forced to 0
- data_valid_out  output  1  one-cycle pulse per processed vertex
- overflow_out  output  1  sticky: a vertex was dropped on a full FIFO
- busy_out  output  1  engine not IDLE or FIFO non-empty

Behaviour:
- Reset: all outputs 0; FIFO emptied; FSM to IDLE; overflow_out cleared.
  - Reset mid-operation abandons the vertex in flight; no data_valid_out is produced for it.
- FIFO push on data_valid_in when not full, or when a pop occurs in the same cycle.
  - Push on a full FIFO with no pop: vertex dropped, overflow_out set until reset.
- Pop when FSM is IDLE and FIFO is non-empty.
- FSM states:
  - IDLE: on pop, latch x/y/z/w and unpack sign/exponent/mantissa (hidden bit restored) -> DIV.
  - DIV: 13 cycles of restoring division, three dividers in parallel (x/w, y/w, z/w mantissas sharing one counter), 13 quotient bits each -> NORM.
  - NORM: normalise each quotient; exponent = ex - ew; convert to signed Q2.14 ndc -> SCALE.
  - SCALE: viewport math into output registers; data_valid_out pulses -> IDLE.
- Latency: vertex written at edge k into an empty FIFO with IDLE engine -> popped at edge k+1 -> data_valid_out high for the cycle after edge k+17.
  - Throughput: one vertex per 16 cycles.
  - A pop may occur on the same edge the FSM returns to IDLE's successor cycle; no bubble beyond IDLE.
- Input classification:
  - Subnormals are flushed to 0.
  - x/y/z zero -> ndc 0.
  - Clip when w sign=1, w=0, w exponent all ones (inf/NaN), any x/y/z inf/NaN, or any |ndc| > 1.0 (i.e. > 16384 in Q2.14).
  - |ndc| == 1.0 exactly is not clipped.
- Viewport, ndc in Q2.14 with 1.0 = 16384:
  - px = ((ndc_x + 16384) * H_RES) >> 15, clamped to H_RES-1.
  - py = ((16384 - ndc_y) * V_RES) >> 15, clamped to V_RES-1.
  - depth = (ndc_z + 16384) << 1, clamped to 0xFFFF.
- On clip: clip_out=1, px/py/depth=0, data_valid_out still pulses.
- px/py/depth/clip_out hold their values until the next data_valid_out.

Test Plan:
- x=0x3800, y=0xB400, z=0x0000, w=0x3C00 -> px=960, py=450, depth=0x8000, clip=0; valid 17 cycles after input.
- x=0x3C00, y=0x4000, z=0x3C00, w=0x4000 (ndc 0.5, 1.0, 0.5) -> px=960, py=0, depth=0xC000, clip=0.
- w=0xBC00 (-1.0), also w=0x0000 and w=0x7C00 -> clip_out=1, px=py=depth=0, data_valid_out pulses once each.
- x=0x4200, w=0x3C00 (ndc_x=3.0) -> clip_out=1; x=0xBC00, w=0x3C00 -> px=0, clip=0.
- Six back-to-back valids, FIFO_DEPTH=4 -> first popped, next four buffered, sixth dropped; overflow_out=1; exactly 5 data_valid_out pulses, in order, 16 cycles apart.
- rst_in asserted during DIV with two vertices queued -> next cycle all outputs 0, busy_out=0, no data_valid_out afterwards; a new vertex then completes with 17-cycle latency.

Source files
------------

// File: rtl/perspective_viewport.sv
// +--------------------------------------------------------------------------+
// | Module      : perspective_viewport                                       |
// | Description : Perspective divide and viewport mapping for binary16       |
// |               clip-space vertices. Input FIFO, three parallel 13-bit     |
// |               restoring mantissa dividers, integer pixel/depth outputs.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module perspective_viewport #(
    parameter int H_RES      = 1280,
    parameter int V_RES      = 720,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic [15:0] w,
    input  logic        data_valid_in,
    output logic [10:0] px_out,
    output logic [9:0]  py_out,
    output logic [15:0] depth_out,
    output logic        clip_out,
    output logic        data_valid_out,
    output logic        overflow_out,
    output logic        busy_out
);

    localparam int              c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_FIFO_FULL = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [1:0]      c_ST_IDLE   = 2'd0;
    localparam logic [1:0]      c_ST_DIV    = 2'd1;
    localparam logic [1:0]      c_ST_NORM   = 2'd2;
    localparam logic [1:0]      c_ST_SCALE  = 2'd3;
    localparam logic [3:0]      c_DIV_LAST  = 4'd12;
    localparam logic [16:0]     c_ONE       = 17'd16384;
    localparam logic [27:0]     c_H         = 28'(H_RES);
    localparam logic [27:0]     c_V         = 28'(V_RES);
    localparam logic [10:0]     c_PX_MAX    = 11'(H_RES - 1);
    localparam logic [9:0]      c_PY_MAX    = 10'(V_RES - 1);

    // Quotient Q (value Q/4096) scaled by 2^s into an unsigned Q2.14 magnitude;
    // saturates when the result is certainly beyond 1.0.
    function automatic logic [16:0] f_to_mag(input logic [12:0] q, input logic signed [6:0] s);
        logic [16:0] v;
        logic [6:0]  n;
        v = {4'b0000, q};
        n = -s;
        if (s > 7'sd3)       f_to_mag = 17'h1FFFF;
        else if (s >= 7'sd0) f_to_mag = v << s;
        else if (n > 7'd12)  f_to_mag = 17'd0;
        else                 f_to_mag = v >> n;
    endfunction

    // ---------------- input FIFO ----------------
    logic [63:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;
    logic [1:0]      r_state;
    logic            w_full, w_empty, w_pop, w_push, w_drop;
    logic [63:0]     w_head;
    logic [15:0]     w_comp [3];

    assign w_full    = (r_count == c_FIFO_FULL);
    assign w_empty   = (r_count == '0);
    assign w_pop     = (r_state == c_ST_IDLE) && !w_empty;
    assign w_push    = data_valid_in && (!w_full || w_pop);
    assign w_drop    = data_valid_in && w_full && !w_pop;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_comp[0] = w_head[63:48];
    assign w_comp[1] = w_head[47:32];
    assign w_comp[2] = w_head[31:16];

    // FIFO storage; pointers are reset, so the array itself needs none
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr_ptr] <= {x, y, z, w};
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // ---------------- engine datapath ----------------
    logic [12:0]        r_rem [3];
    logic [12:0]        r_quo [3];
    logic [4:0]         r_exp [3];
    logic [2:0]         r_sign, r_zero;
    logic [4:0]         r_exp_w;
    logic [10:0]        r_man_w;
    logic               r_clip_in, r_clip;
    logic [3:0]         r_div_cnt;
    logic signed [15:0] r_ndc [3];
    logic [10:0]        r_pend_px;
    logic [9:0]         r_pend_py;
    logic [15:0]        r_pend_depth;
    logic               r_pend_clip, r_fire;

    logic [2:0]         w_ge, w_over;
    logic [12:0]        w_rem_nx [3];
    logic signed [6:0]  w_shift [3];
    logic [16:0]        w_mag [3];
    logic [15:0]        w_ndc_n [3];

    // One restoring-division step and the quotient-to-Q2.14 conversion per channel
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_ge[i]     = (r_rem[i] >= {2'b00, r_man_w});
            w_rem_nx[i] = w_ge[i] ? 13'((r_rem[i] - {2'b00, r_man_w}) << 1) : 13'(r_rem[i] << 1);
            w_shift[i]  = $signed({2'b00, r_exp[i]}) - $signed({2'b00, r_exp_w}) + 7'sd2;
            w_mag[i]    = f_to_mag(r_quo[i], w_shift[i]);
            w_over[i]   = !r_zero[i] && (w_mag[i] > c_ONE);
            w_ndc_n[i]  = r_zero[i] ? 16'd0 : (r_sign[i] ? -w_mag[i][15:0] : w_mag[i][15:0]);
        end
    end

    logic [16:0] w_off_x, w_off_y, w_off_z;
    logic [27:0] w_px_prod, w_py_prod, w_px_sh, w_py_sh;
    logic [17:0] w_depth_full;
    logic [10:0] w_px;
    logic [9:0]  w_py;
    logic [15:0] w_depth;

    // Viewport mapping of the registered ndc triple, with range clamps
    always_comb begin
        w_off_x      = {r_ndc[0][15], r_ndc[0]} + c_ONE;
        w_off_y      = c_ONE - {r_ndc[1][15], r_ndc[1]};
        w_off_z      = {r_ndc[2][15], r_ndc[2]} + c_ONE;
        w_px_prod    = {11'd0, w_off_x} * c_H;
        w_py_prod    = {11'd0, w_off_y} * c_V;
        w_px_sh      = w_px_prod >> 15;
        w_py_sh      = w_py_prod >> 15;
        w_px         = (w_px_sh >= c_H) ? c_PX_MAX : w_px_sh[10:0];
        w_py         = (w_py_sh >= c_V) ? c_PY_MAX : w_py_sh[9:0];
        w_depth_full = {w_off_z, 1'b0};
        w_depth      = (w_depth_full > 18'h0FFFF) ? 16'hFFFF : w_depth_full[15:0];
    end

    // Engine FSM: unpack on pop, 13 divide steps, normalise to ndc, viewport scale
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= c_ST_IDLE;
            r_div_cnt    <= '0;
            r_fire       <= 1'b0;
            r_clip_in    <= 1'b0;
            r_clip       <= 1'b0;
            r_sign       <= '0;
            r_zero       <= '0;
            r_exp_w      <= '0;
            r_man_w      <= '0;
            r_pend_px    <= '0;
            r_pend_py    <= '0;
            r_pend_depth <= '0;
            r_pend_clip  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_rem[i] <= '0;
                r_quo[i] <= '0;
                r_exp[i] <= '0;
                r_ndc[i] <= '0;
            end
        end else begin
            r_fire <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_exp_w   <= w_head[14:10];
                        r_man_w   <= {1'b1, w_head[9:0]};
                        r_clip_in <= w_head[15] || (w_head[14:10] == 5'd0) ||
                                     (w_head[14:10] == 5'h1F) ||
                                     (w_comp[0][14:10] == 5'h1F) ||
                                     (w_comp[1][14:10] == 5'h1F) ||
                                     (w_comp[2][14:10] == 5'h1F);
                        for (int i = 0; i < 3; i++) begin
                            // exponent 0 covers both zero and flushed subnormals
                            r_zero[i] <= (w_comp[i][14:10] == 5'd0);
                            r_sign[i] <= w_comp[i][15];
                            r_exp[i]  <= w_comp[i][14:10];
                            r_rem[i]  <= (w_comp[i][14:10] == 5'd0) ? 13'd0 : {2'b01, w_comp[i][9:0]};
                            r_quo[i]  <= '0;
                        end
                        r_div_cnt <= '0;
                        r_state   <= c_ST_DIV;
                    end
                end
                c_ST_DIV: begin
                    for (int i = 0; i < 3; i++) begin
                        r_rem[i] <= w_rem_nx[i];
                        r_quo[i] <= {r_quo[i][11:0], w_ge[i]};
                    end
                    if (r_div_cnt == c_DIV_LAST) r_state <= c_ST_NORM;
                    else                         r_div_cnt <= r_div_cnt + 1'b1;
                end
                c_ST_NORM: begin
                    for (int i = 0; i < 3; i++) r_ndc[i] <= $signed(w_ndc_n[i]);
                    r_clip  <= r_clip_in || (|w_over);
                    r_state <= c_ST_SCALE;
                end
                default: begin
                    r_pend_px    <= r_clip ? 11'd0 : w_px;
                    r_pend_py    <= r_clip ? 10'd0 : w_py;
                    r_pend_depth <= r_clip ? 16'd0 : w_depth;
                    r_pend_clip  <= r_clip;
                    r_fire       <= 1'b1;
                    r_state      <= c_ST_IDLE;
                end
            endcase
        end
    end

    logic [10:0] r_px;
    logic [9:0]  r_py;
    logic [15:0] r_depth;
    logic        r_clip_o, r_valid_o;

    // Output registers: updated only on a completed vertex, held otherwise
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_px      <= '0;
            r_py      <= '0;
            r_depth   <= '0;
            r_clip_o  <= 1'b0;
            r_valid_o <= 1'b0;
        end else begin
            r_valid_o <= r_fire;
            if (r_fire) begin
                r_px     <= r_pend_px;
                r_py     <= r_pend_py;
                r_depth  <= r_pend_depth;
                r_clip_o <= r_pend_clip;
            end
        end
    end

    assign px_out         = r_px;
    assign py_out         = r_py;
    assign depth_out      = r_depth;
    assign clip_out       = r_clip_o;
    assign data_valid_out = r_valid_o;
    assign overflow_out   = r_overflow;
    assign busy_out       = (r_state != c_ST_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_perspective_viewport.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_perspective_viewport                                    |
// | Description : Scoreboard bench for perspective_viewport with an          |
// |               arithmetic reference model and directed corner vertices.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_perspective_viewport;

    localparam int H_RES      = 1280;
    localparam int V_RES      = 720;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] x = '0, y = '0, z = '0, w = '0;
    logic        data_valid_in = 1'b0;
    logic [10:0] px_out;
    logic [9:0]  py_out;
    logic [15:0] depth_out;
    logic        clip_out, data_valid_out, overflow_out, busy_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [10:0] px;
        logic [9:0]  py;
        logic [15:0] depth;
        logic        clip;
        int          due;
    } exp_t;

    exp_t sb[$];

    perspective_viewport #(.H_RES(H_RES), .V_RES(V_RES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_in(clk), .rst_in(rst_in), .x(x), .y(y), .z(z), .w(w),
        .data_valid_in(data_valid_in), .px_out(px_out), .py_out(py_out),
        .depth_out(depth_out), .clip_out(clip_out), .data_valid_out(data_valid_out),
        .overflow_out(overflow_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: real ratio |c|/|w| truncated to 13 significant quotient bits, then
    // scaled to Q2.14 and mapped through the viewport formulas.
    function automatic exp_t model(input logic [15:0] vx, vy, vz, vw, input int due);
        exp_t        r;
        logic [15:0] c [3];
        int          ew, ec, sh, px, py, dp;
        int          ndc [3];
        longint      mw, q, mag;
        bit          clip;
        c[0] = vx; c[1] = vy; c[2] = vz;
        ew   = int'(vw[14:10]);
        mw   = 1024 + longint'(vw[9:0]);
        clip = vw[15] || ew == 0 || ew == 31;
        for (int i = 0; i < 3; i++) begin
            ec     = int'(c[i][14:10]);
            ndc[i] = 0;
            if (ec == 31) clip = 1;
            else if (ec != 0) begin
                q   = ((1024 + longint'(c[i][9:0])) * 4096) / mw;
                sh  = 2 + ec - ew;
                mag = (sh >= 0) ? (q << sh) : (q >> (-sh));
                if (mag > 16384) clip = 1;
                else ndc[i] = c[i][15] ? -int'(mag) : int'(mag);
            end
        end
        r.due = due;
        if (clip) begin
            r.px = '0; r.py = '0; r.depth = '0; r.clip = 1'b1;
        end else begin
            px = ((ndc[0] + 16384) * H_RES) / 32768;
            py = ((16384 - ndc[1]) * V_RES) / 32768;
            dp = (ndc[2] + 16384) * 2;
            r.px    = 11'((px > H_RES - 1) ? H_RES - 1 : px);
            r.py    = 10'((py > V_RES - 1) ? V_RES - 1 : py);
            r.depth = 16'((dp > 65535) ? 65535 : dp);
            r.clip  = 1'b0;
        end
        return r;
    endfunction

    function automatic exp_t mk(input int px, py, depth, input bit clip, input int due);
        exp_t r;
        r.px = 11'(px); r.py = 10'(py); r.depth = 16'(depth); r.clip = clip; r.due = due;
        return r;
    endfunction

    function automatic logic [15:0] rnd_comp(input int ew);
        int e;
        e = ew - 4 + int'($urandom_range(0, 5));
        return {1'($urandom_range(0, 1)), 5'(e), 10'($urandom)};
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Called at a negedge; presents one vertex for the next posedge
    task automatic drive(input logic [15:0] vx, vy, vz, vw, output int edge_no);
        x = vx; y = vy; z = vz; w = vw;
        data_valid_in = 1'b1;
        edge_no = cyc + 1;
        @(negedge clk);
        data_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vertices never emitted, required 0", sb.size());
            sb.delete();
        end
        idle(3);
    endtask

    // Monitor: every output pulse is matched against the oldest expected entry
    always @(negedge clk) begin : monitor
        exp_t e;
        if (data_valid_out) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: cycle %0d got px=%0d py=%0d depth=%0h clip=%0b, required no pulse",
                         cyc, px_out, py_out, depth_out, clip_out);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if ({px_out, py_out, depth_out, clip_out} !== {e.px, e.py, e.depth, e.clip}) begin
                    n_bad++;
                    $display("FAIL vertex: got px=%0d py=%0d depth=%0h clip=%0b, required px=%0d py=%0d depth=%0h clip=%0b",
                             px_out, py_out, depth_out, clip_out, e.px, e.py, e.depth, e.clip);
                end
                if (e.due >= 0) begin
                    n_cmp++;
                    if (cyc != e.due) begin
                        n_bad++;
                        $display("FAIL latency: pulse after edge %0d, required edge %0d", cyc, e.due);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k0;
        exp_t e;
        logic [15:0] vx, vy, vz, vw;
        int ew;

        // reset state
        idle(3);
        rst_in = 1'b0;
        chk("reset_px", px_out, 0);
        chk("reset_py", py_out, 0);
        chk("reset_depth", depth_out, 0);
        chk("reset_clip", clip_out, 0);
        chk("reset_valid", data_valid_out, 0);
        chk("reset_overflow", overflow_out, 0);
        chk("reset_busy", busy_out, 0);

        // basic mapping with latency
        drive(16'h3800, 16'hB400, 16'h0000, 16'h3C00, k);
        sb.push_back(mk(960, 450, 16'h8000, 1'b0, k + 17));
        chk("busy_active", busy_out, 1);
        drain(40);

        // ndc exactly 1.0 on y is not clipped
        drive(16'h3C00, 16'h4000, 16'h3C00, 16'h4000, k);
        sb.push_back(mk(960, 0, 16'hC000, 1'b0, k + 17));
        drain(40);

        // w negative, zero, infinite
        drive(16'h3800, 16'hB400, 16'h0000, 16'hBC00, k);
        sb.push_back(mk(0, 0, 0, 1'b1, k + 17));
        idle(19);
        drive(16'h3800, 16'hB400, 16'h0000, 16'h0000, k);
        sb.push_back(mk(0, 0, 0, 1'b1, k + 17));
        idle(19);
        drive(16'h3800, 16'hB400, 16'h0000, 16'h7C00, k);
        sb.push_back(mk(0, 0, 0, 1'b1, k + 17));
        drain(60);

        // ndc_x = 3.0 clips; ndc_x = -1.0 maps to column 0
        drive(16'h4200, 16'h0000, 16'h0000, 16'h3C00, k);
        sb.push_back(mk(0, 0, 0, 1'b1, k + 17));
        idle(19);
        drive(16'hBC00, 16'h0000, 16'h0000, 16'h3C00, k);
        sb.push_back(mk(0, 360, 16'h8000, 1'b0, k + 17));
        drain(60);

        // six back-to-back vertices: first popped, four buffered, sixth dropped
        chk("overflow_before", overflow_out, 0);
        for (int i = 0; i < 6; i++) begin
            ew = int'($urandom_range(12, 18));
            vw = {1'b0, 5'(ew), 10'($urandom)};
            vx = rnd_comp(ew); vy = rnd_comp(ew); vz = rnd_comp(ew);
            drive(vx, vy, vz, vw, k);
            if (i == 0) k0 = k;
            if (i < 5) sb.push_back(model(vx, vy, vz, vw, k0 + 17 + 16 * i));
        end
        chk("overflow_set", overflow_out, 1);
        drain(150);

        // randomized vertices, spaced so the FIFO never fills
        for (int i = 0; i < 40; i++) begin
            if ((i % 4) == 3) begin
                vx = 16'($urandom); vy = 16'($urandom); vz = 16'($urandom); vw = 16'($urandom);
            end else begin
                ew = int'($urandom_range(12, 18));
                vw = {1'b0, 5'(ew), 10'($urandom)};
                vx = rnd_comp(ew); vy = rnd_comp(ew); vz = rnd_comp(ew);
            end
            drive(vx, vy, vz, vw, k);
            sb.push_back(model(vx, vy, vz, vw, k + 17));
            idle(int'($urandom_range(15, 18)));
        end
        drain(100);
        chk("overflow_sticky", overflow_out, 1);

        // reset during DIV with two vertices queued
        drive(16'h3800, 16'hB400, 16'h0000, 16'h3C00, k);
        drive(16'h3C00, 16'h4000, 16'h3C00, 16'h4000, k);
        drive(16'hBC00, 16'h0000, 16'h0000, 16'h3C00, k);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        chk("midrst_px", px_out, 0);
        chk("midrst_py", py_out, 0);
        chk("midrst_depth", depth_out, 0);
        chk("midrst_clip", clip_out, 0);
        chk("midrst_valid", data_valid_out, 0);
        chk("midrst_overflow", overflow_out, 0);
        chk("midrst_busy", busy_out, 0);
        idle(40);
        drive(16'h3800, 16'hB400, 16'h0000, 16'h3C00, k);
        sb.push_back(mk(960, 450, 16'h8000, 1'b0, k + 17));
        drain(40);
        chk("idle_after_drain", busy_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
